// File: rtl/bram_resp_dump.sv
// Memory end of the controller's 32-bit BRAM port. Port A serves byte-lane
// writes and fixed-latency reads; port B drains a result window on done's rising edge.
module bram_resp_dump #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int READ_LATENCY    = 1,
  parameter int DUMP_BASE       = 0,
  parameter int DUMP_WORDS      = 64
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       BRAM_EN,
  input  logic                       BRAM_RST,
  input  logic [31:0]                BRAM_ADDR,
  input  logic [31:0]                BRAM_WRDATA,
  input  logic [3:0]                 BRAM_WE,
  output logic [31:0]                BRAM_RDDATA,
  input  logic                       done,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [31:0]                dump_data,
  output logic [BRAM_ADDR_WIDTH-3:0] dump_index,
  output logic                       dump_last,
  output logic                       busy
);

  localparam int AW    = BRAM_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] BASE_IDX = AW'(DUMP_BASE % DEPTH);
  localparam logic [AW-1:0] LAST_CNT = AW'(DUMP_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, REARM} state_e;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] widx;
  logic          unused_addr;

  assign widx        = BRAM_ADDR[BRAM_ADDR_WIDTH-1:2];
  assign unused_addr = ^{BRAM_ADDR[31:BRAM_ADDR_WIDTH], BRAM_ADDR[1:0]};

  // Port A write: enabled byte lanes only
  always_ff @(posedge aclk) begin
    if (BRAM_EN) begin
      for (int i = 0; i < 4; i++) begin
        if (BRAM_WE[i]) mem[widx][8*i +: 8] <= BRAM_WRDATA[8*i +: 8];
      end
    end
  end

  // Port A read pipeline. Stage 1 samples the pre-write word (read-first);
  // stage 2 advances only when stage 1 took a read, so idle cycles hold data.
  logic [31:0] s1_q, s2_q;
  logic        en_q;

  always_ff @(posedge aclk) begin
    if (areset || BRAM_RST) begin
      s1_q <= '0;
      s2_q <= '0;
      en_q <= 1'b0;
    end else begin
      en_q <= BRAM_EN;
      if (BRAM_EN) s1_q <= mem[widx];
      if (en_q)    s2_q <= s1_q;
    end
  end

  assign BRAM_RDDATA = (READ_LATENCY == 2) ? s2_q : s1_q;

  // Dump engine
  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, cnt_q, cnt_d, idx_q, idx_d;
  logic          valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q;
  logic [31:0]   data_q;
  logic          rise;

  assign rise = done & ~done_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done;
    end
  end

  // Port B: read-only snapshot taken on the edge leaving FETCH
  always_ff @(posedge aclk) begin
    if (areset)                data_q <= '0;
    else if (state_q == FETCH) data_q <= mem[ptr_q];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          ptr_d   = BASE_IDX;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        idx_d   = ptr_q;
        last_d  = (cnt_q == LAST_CNT);
        valid_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (valid_q && dump_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            busy_d  = 1'b0;
            state_d = REARM;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      REARM: begin
        if (!done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dump_valid = valid_q;
  assign dump_data  = data_q;
  assign dump_index = idx_q;
  assign dump_last  = last_q;
  assign busy       = busy_q;

endmodule
